mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage access controller. Non-memory ops pass the ALU result straight
//   to writeback. Memory ops are checked for alignment and then issued as a
//   single request/acknowledge transaction on a simple memory port. The
//   controller stalls the pipeline while the access is outstanding and gives up
//   after TIMEOUT cycles without an acknowledge. Memory is big-endian: byte
//   offset 0 is bits 31:24.
//
//   Ports
//     clk, Reset          clock, synchronous active-low reset
//     MEM_RB_in           store data
//     MEM_ALU_OUT_in      effective byte address or ALU result
//     MEM_RD_in           destination register
//     MEM_RAM_CTRL_in     [3] enable, [2] write, [1:0] size (00 B, 01 H, 1x W)
//     MEM_L_in            writeback source: 1 load data, 0 ALU result
//     MEM_RF_LE_in        register-file load enable
//     mem_ack, mem_rdata  memory completion and read word
//     mem_req, mem_we     request and write strobe
//     mem_addr            word-aligned address
//     mem_wdata, mem_be   lane-replicated store data and byte enables
//     WB_DATA_out, WB_RD_out, WB_RF_LE_out   registered writeback
//     MEM_STALL_out       combinational stall to upstream stages
//     MEM_ERR_out         one-cycle fault pulse (misalignment or timeout)
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no access in flight; ops are decoded as they arrive
//   ACCESS | request issued, waiting for mem_ack or the timeout

module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] MEM_RB_in,
    input  logic [31:0] MEM_ALU_OUT_in,
    input  logic [4:0]  MEM_RD_in,
    input  logic [3:0]  MEM_RAM_CTRL_in,
    input  logic        MEM_L_in,
    input  logic        MEM_RF_LE_in,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] WB_DATA_out,
    output logic [4:0]  WB_RD_out,
    output logic        WB_RF_LE_out,
    output logic        MEM_STALL_out,
    output logic        MEM_ERR_out
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_rf_le_q, wb_rf_le_d;
    logic          mem_err_q, mem_err_d;
    // Op fields captured at ACCESS entry; upstream is held but not trusted.
    logic [31:0]   lat_alu_q, lat_alu_d;
    logic [4:0]    lat_rd_q, lat_rd_d;
    logic [1:0]    lat_size_q, lat_size_d;
    logic          lat_l_q, lat_l_d;
    logic          lat_rf_le_q, lat_rf_le_d;

    logic          op_mem;
    logic          op_misaligned;
    logic          stall;

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] rb);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{rb[7:0]}};
            2'b01:   w = {2{rb[15:0]}};
            default: w = rb;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b1000 >> off;
            2'b01:   be = off[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] v;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    v = {24'd0, rdata[31:24]};
                    2'd1:    v = {24'd0, rdata[23:16]};
                    2'd2:    v = {24'd0, rdata[15:8]};
                    default: v = {24'd0, rdata[7:0]};
                endcase
            end
            2'b01:   v = off[1] ? {16'd0, rdata[15:0]} : {16'd0, rdata[31:16]};
            default: v = rdata;
        endcase
        return v;
    endfunction

    always_comb begin
        op_mem = MEM_RAM_CTRL_in[3];
        case (MEM_RAM_CTRL_in[1:0])
            2'b00:   op_misaligned = 1'b0;
            2'b01:   op_misaligned = MEM_ALU_OUT_in[0];
            default: op_misaligned = |MEM_ALU_OUT_in[1:0];
        endcase
    end

    // The final timeout cycle does not stall: the op is retired as a fault.
    always_comb begin
        stall = 1'b0;
        if (Reset) begin
            if (state_q == IDLE) begin
                stall = op_mem & ~op_misaligned;
            end else begin
                stall = ~mem_ack & (cnt_q != CNT_LAST);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_rf_le_d  = wb_rf_le_q;
        mem_err_d   = 1'b0;
        lat_alu_d   = lat_alu_q;
        lat_rd_d    = lat_rd_q;
        lat_size_d  = lat_size_q;
        lat_l_d     = lat_l_q;
        lat_rf_le_d = lat_rf_le_q;

        case (state_q)
            IDLE: begin
                if (!op_mem) begin
                    wb_data_d  = MEM_ALU_OUT_in;
                    wb_rd_d    = MEM_RD_in;
                    wb_rf_le_d = MEM_RF_LE_in;
                end else if (op_misaligned) begin
                    wb_rf_le_d = 1'b0;
                    mem_err_d  = 1'b1;
                end else begin
                    state_d     = ACCESS;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MEM_RAM_CTRL_in[2];
                    mem_addr_d  = {MEM_ALU_OUT_in[31:2], 2'b00};
                    mem_wdata_d = store_lanes(MEM_RAM_CTRL_in[1:0], MEM_RB_in);
                    mem_be_d    = byte_en(MEM_RAM_CTRL_in[1:0], MEM_ALU_OUT_in[1:0]);
                    wb_rf_le_d  = 1'b0;
                    lat_alu_d   = MEM_ALU_OUT_in;
                    lat_rd_d    = MEM_RD_in;
                    lat_size_d  = MEM_RAM_CTRL_in[1:0];
                    lat_l_d     = MEM_L_in;
                    lat_rf_le_d = MEM_RF_LE_in;
                end
            end
            default: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    wb_data_d  = lat_l_q ? load_extract(lat_size_q, lat_alu_q[1:0], mem_rdata)
                                         : lat_alu_q;
                    wb_rd_d    = lat_rd_q;
                    wb_rf_le_d = lat_rf_le_q & ~mem_we_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    wb_rf_le_d = 1'b0;
                    mem_err_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    wb_rf_le_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_rf_le_q  <= 1'b0;
            mem_err_q   <= 1'b0;
            lat_alu_q   <= '0;
            lat_rd_q    <= '0;
            lat_size_q  <= '0;
            lat_l_q     <= 1'b0;
            lat_rf_le_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_rf_le_q  <= wb_rf_le_d;
            mem_err_q   <= mem_err_d;
            lat_alu_q   <= lat_alu_d;
            lat_rd_q    <= lat_rd_d;
            lat_size_q  <= lat_size_d;
            lat_l_q     <= lat_l_d;
            lat_rf_le_q <= lat_rf_le_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    assign WB_DATA_out   = wb_data_q;
    assign WB_RD_out     = wb_rd_q;
    assign WB_RF_LE_out  = wb_rf_le_q;
    assign MEM_STALL_out = stall;
    assign MEM_ERR_out   = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios with literal expectations,
// then randomized ops, all compared every cycle against a transaction-level
// model that derives lanes from big-endian byte ranges.

module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] MEM_RB_in;
    logic [31:0] MEM_ALU_OUT_in;
    logic [4:0]  MEM_RD_in;
    logic [3:0]  MEM_RAM_CTRL_in;
    logic        MEM_L_in;
    logic        MEM_RF_LE_in;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] WB_DATA_out;
    logic [4:0]  WB_RD_out;
    logic        WB_RF_LE_out;
    logic        MEM_STALL_out;
    logic        MEM_ERR_out;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .Reset           (Reset),
        .MEM_RB_in       (MEM_RB_in),
        .MEM_ALU_OUT_in  (MEM_ALU_OUT_in),
        .MEM_RD_in       (MEM_RD_in),
        .MEM_RAM_CTRL_in (MEM_RAM_CTRL_in),
        .MEM_L_in        (MEM_L_in),
        .MEM_RF_LE_in    (MEM_RF_LE_in),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .WB_DATA_out     (WB_DATA_out),
        .WB_RD_out       (WB_RD_out),
        .WB_RF_LE_out    (WB_RF_LE_out),
        .MEM_STALL_out   (MEM_STALL_out),
        .MEM_ERR_out     (MEM_ERR_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: one outstanding transaction plus the expected registered outputs.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    logic [31:0] l_alu;
    logic [4:0]  l_rd;
    bit          l_load, l_le, l_write;
    int          l_n, l_off;
    bit          e_req = 0, e_we = 0, e_wble = 0, e_err = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_wbdata = '0;
    logic [3:0]  e_be = '0;
    logic [4:0]  e_wbrd = '0;
    bit          wb_def = 1'b0, addr_def = 1'b0;
    bit          consumed = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] lanes_be(input int n, input int off);
        logic [3:0] b;
        b = '0;
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + n) b[3-k] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] lanes_wdata(input int n, input logic [31:0] rb);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            w[31-8*k -: 8] = rb[8*((n-1) - (k % n)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] lanes_load(input int n, input int off, input logic [31:0] rd);
        logic [31:0] v;
        v = '0;
        for (int k = off; k < off + n; k++)
            v = (v << 8) | {24'd0, rd[31-8*k -: 8]};
        return v;
    endfunction

    function automatic bit op_aligned();
        return (int'(MEM_ALU_OUT_in[1:0]) % nbytes(MEM_RAM_CTRL_in[1:0])) == 0;
    endfunction

    function automatic bit exp_stall();
        if (!Reset) return 1'b0;
        if (!m_busy) return MEM_RAM_CTRL_in[3] && op_aligned();
        return !mem_ack && (m_wait != TIMEOUT - 1);
    endfunction

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_step();
        e_err = 1'b0;
        if (!Reset) begin
            m_busy = 1'b0; e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_be = '0;
            e_wbdata = '0; e_wbrd = '0; e_wble = 0;
            wb_def = 1'b1; addr_def = 1'b1;
        end else if (!m_busy) begin
            if (!MEM_RAM_CTRL_in[3]) begin
                e_wbdata = MEM_ALU_OUT_in; e_wbrd = MEM_RD_in; e_wble = MEM_RF_LE_in;
                wb_def = 1'b1;
            end else if (!op_aligned()) begin
                e_wble = 0; e_err = 1'b1; wb_def = 1'b0;
            end else begin
                m_busy = 1'b1; m_wait = 0;
                l_alu = MEM_ALU_OUT_in; l_rd = MEM_RD_in; l_load = MEM_L_in;
                l_le = MEM_RF_LE_in; l_write = MEM_RAM_CTRL_in[2];
                l_n = nbytes(MEM_RAM_CTRL_in[1:0]); l_off = int'(MEM_ALU_OUT_in[1:0]);
                e_req = 1; e_we = l_write; e_addr = l_alu & 32'hFFFF_FFFC;
                e_wdata = lanes_wdata(l_n, MEM_RB_in); e_be = lanes_be(l_n, l_off);
                e_wble = 0; addr_def = 1'b1; wb_def = 1'b0;
            end
        end else begin
            wb_def = 1'b0;
            if (mem_ack) begin
                m_busy = 1'b0; e_req = 0; e_we = 0; addr_def = 1'b0;
                e_wbdata = l_load ? lanes_load(l_n, l_off, mem_rdata) : l_alu;
                e_wbrd = l_rd; e_wble = l_le && !l_write; wb_def = 1'b1;
            end else if (m_wait == TIMEOUT - 1) begin
                m_busy = 1'b0; e_req = 0; e_we = 0; e_wble = 0; e_err = 1'b1;
                addr_def = 1'b0;
            end else begin
                m_wait++; e_wble = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        chk("mem_req", mem_req, e_req);
        chk("mem_we", mem_we, e_we);
        chk("wb_rf_le", WB_RF_LE_out, e_wble);
        chk("mem_err", MEM_ERR_out, e_err);
        if (addr_def) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_be", mem_be, e_be);
        end
        if (wb_def) begin
            chk("wb_data", WB_DATA_out, e_wbdata);
            chk("wb_rd", WB_RD_out, e_wbrd);
        end
    endtask

    // Inputs are set just after a falling edge; stall is sampled 1 ns later,
    // the model steps before the rising edge, outputs are sampled after the
    // next falling edge.
    task automatic tick();
        #1;
        chk("stall", MEM_STALL_out, exp_stall());
        consumed = !exp_stall();
        model_step();
        @(negedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic lit_stall(input string name, input bit exp);
        #1;
        chk(name, MEM_STALL_out, exp);
    endtask

    task automatic set_op(input logic [31:0] alu, input logic [31:0] rb, input logic [3:0] ctrl,
                          input logic [4:0] rd, input bit ld, input bit le);
        MEM_ALU_OUT_in = alu; MEM_RB_in = rb; MEM_RAM_CTRL_in = ctrl;
        MEM_RD_in = rd; MEM_L_in = ld; MEM_RF_LE_in = le;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        int req_cnt;
        bit ack_mode;

        Reset = 1'b0;
        set_op(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        mem_ack = 1'b0;
        mem_rdata = '0;
        @(negedge clk); #1;
        tick();
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_wbdata", WB_DATA_out, 0);
        chk("rst_err", MEM_ERR_out, 0);
        Reset = 1'b1;

        // ALU passthrough
        set_op(32'h12345678, 32'h0, 4'h0, 5'd5, 1'b0, 1'b1);
        lit_stall("alu_stall", 1'b0);
        tick();
        chk("alu_wbdata", WB_DATA_out, 32'h12345678);
        chk("alu_wbrd", WB_RD_out, 5);
        chk("alu_wble", WB_RF_LE_out, 1);

        // Byte load at 0x101, ack after three waiting cycles
        set_op(32'h101, 32'h0, 4'b1000, 5'd7, 1'b1, 1'b1);
        mem_rdata = 32'hAABBCCDD;
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (MEM_STALL_out) stall_cnt++;
            tick();
        end
        mem_ack = 1'b1;
        #1;
        if (MEM_STALL_out) stall_cnt++;
        tick();
        chk("bload_stall_cycles", stall_cnt, 4);
        chk("bload_wbdata", WB_DATA_out, 32'h000000BB);
        chk("bload_wbrd", WB_RD_out, 7);
        chk("bload_wble", WB_RF_LE_out, 1);
        mem_ack = 1'b0;
        set_op(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        tick();

        // Half store at 0x202
        set_op(32'h202, 32'h0000BEEF, 4'b1101, 5'd3, 1'b0, 1'b1);
        tick();
        chk("hst_req", mem_req, 1);
        chk("hst_we", mem_we, 1);
        chk("hst_addr", mem_addr, 32'h200);
        chk("hst_be", mem_be, 4'b0011);
        chk("hst_wdata", mem_wdata, 32'hBEEFBEEF);
        chk("hst_wble", WB_RF_LE_out, 0);
        mem_ack = 1'b1;
        tick();
        chk("hst_done_wble", WB_RF_LE_out, 0);
        chk("hst_done_req", mem_req, 0);
        mem_ack = 1'b0;

        // Misaligned word load
        set_op(32'h103, 32'h0, 4'b1010, 5'd9, 1'b1, 1'b1);
        lit_stall("mis_stall", 1'b0);
        tick();
        chk("mis_req", mem_req, 0);
        chk("mis_err", MEM_ERR_out, 1);
        chk("mis_wble", WB_RF_LE_out, 0);
        set_op(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("mis_err_pulse", MEM_ERR_out, 0);

        // Timeout: word load, never acknowledged
        set_op(32'h100, 32'h0, 4'b1010, 5'd4, 1'b1, 1'b1);
        tick();
        req_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            req_cnt++;
            #1;
            chk("to_stall", MEM_STALL_out, (req_cnt < TIMEOUT));
            tick();
        end
        chk("to_req_cycles", req_cnt, TIMEOUT);
        chk("to_err", MEM_ERR_out, 1);
        chk("to_wble", WB_RF_LE_out, 0);
        set_op(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        lit_stall("to_released", 1'b0);
        tick();
        chk("to_err_pulse", MEM_ERR_out, 0);

        // Reset in the second ACCESS cycle, then a stray ack
        set_op(32'h300, 32'h0, 4'b1010, 5'd6, 1'b1, 1'b1);
        tick();
        tick();
        Reset = 1'b0;
        tick();
        chk("rac_req", mem_req, 0);
        chk("rac_addr", mem_addr, 0);
        chk("rac_be", mem_be, 0);
        chk("rac_wble", WB_RF_LE_out, 0);
        chk("rac_wbdata", WB_DATA_out, 0);
        Reset = 1'b1;
        set_op(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        tick();
        chk("rac_ack_req", mem_req, 0);
        chk("rac_ack_wble", WB_RF_LE_out, 0);
        chk("rac_ack_wbdata", WB_DATA_out, 0);
        mem_ack = 1'b0;

        // Randomized traffic
        ack_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (consumed) begin
                set_op($urandom, $urandom,
                       {($urandom_range(0, 2) != 0), 1'($urandom), 2'($urandom)},
                       5'($urandom), 1'($urandom), 1'($urandom));
                ack_mode = ($urandom_range(0, 7) != 0);
            end
            Reset = ($urandom_range(0, 299) != 0);
            mem_ack = ack_mode && ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
